pipe_share_sched: RTL and testbench
===================================

# pipe_share_sched

Round-robin scheduler that shares one fixed-latency, non-stallable datapath (a flip-flop delay pipeline of LATENCY cycles) among NREQ requesters. It accepts operands over per-requester valid/ready handshakes, issues at most one per cycle into the datapath, tracks requester IDs alongside the data in a matching tag pipeline, and buffers results in a response FIFO. Credit-based issue guarantees the FIFO never overflows, so the datapath itself needs no stall.

## Interface
- NREQ, 4: number of requesters, ≥1.
- WIDTH, 8: operand/result width.
- LATENCY, 5: datapath latency in cycles, ≥1; must equal the attached datapath's latency.
- DEPTH, 8: response FIFO depth and credit count, ≥1. Full throughput needs DEPTH ≥ LATENCY+2.
- ID_W (localparam): max(1, $clog2(NREQ)).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset; deassertion synchronized externally.
- req_valid  in  NREQ  per-requester operand valid.
- req_data  in  NREQ*WIDTH  operands; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot or zero grant; handshake when req_valid[i]&req_ready[i].
- pipe_in_valid  out  1  operand issued to datapath this cycle.
- pipe_in_data  out  WIDTH  datapath input.
- pipe_out_data  in  WIDTH  datapath output, LATENCY cycles after pipe_in_data.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer accepts head.
- rsp_id  out  ID_W  requester index of head.
- rsp_data  out  WIDTH  result at head.

## Operation
- Credit count `cnt` = issue register + tag-pipe valids + FIFO occupancy, range 0..DEPTH.
- Issue permitted iff cnt < DEPTH. A credit freed by a rsp handshake becomes usable the following cycle.
- Arbitration is combinational over req_valid and evaluated only when issue is permitted.
  - Search starts at pointer `ptr` and wraps modulo NREQ; the first valid requester is granted.
  - req_ready[i]=1 only for that requester. No grant when no requester is valid or cnt = DEPTH.
  - req_ready never depends on rsp_ready.
- On a grant, `ptr` ← (granted index + 1) mod NREQ; otherwise `ptr` is unchanged.
- The issue register captures {valid, id, data}. pipe_in_valid/pipe_in_data are driven from it.
- The tag pipeline is LATENCY stages of {valid, id} that mirror the datapath.
  - When its last stage is valid, {id, pipe_out_data} is pushed into the FIFO.
  - pipe_out_data is ignored when that stage is invalid.
- The FIFO is first-word-fall-through. rsp_valid = FIFO not empty.
  - Pop on rsp_valid & rsp_ready.
  - Push and pop in the same cycle are both legal, including when the FIFO is full.
  - Overflow is impossible by construction; the bench asserts it.
- Results return in issue order across all requesters.
- Counter arithmetic: cnt_next = cnt + issue − pop. Width is $clog2(DEPTH+1). No wrap is possible.

## Timing
- Reset (async assert) takes effect immediately:
  - req_ready=0, pipe_in_valid=0, pipe_in_data=0, rsp_valid=0, rsp_id=0, rsp_data=0.
  - ptr=0, cnt=0, all tag valids=0, FIFO empty.
- Reset mid-operation discards in-flight and buffered results. Datapath outputs arriving afterward are ignored because their tags are cleared.
- Handshake at edge t:
  - pipe_in_valid is high in cycle t..t+1.
  - The result is pushed at edge t+1+LATENCY.
  - rsp_valid is high from cycle after that edge, i.e. LATENCY+2 cycles after acceptance when the FIFO was empty.
- Sustained throughput is one operation per cycle when DEPTH ≥ LATENCY+2 and rsp_ready=1.
- rsp_valid/rsp_id/rsp_data hold stable while rsp_valid & !rsp_ready.

## Structure
- Shared package pipe_sched_pkg holds:
  - function id_width(n), returning max(1, $clog2(n));
  - packed struct tag_t {valid, id}, parameterized through a localparam typedef in the module.
- One sub-module, sched_fifo: FWFT FIFO with async active-low reset, parameters WIDTH and DEPTH, ports push/pop/full/empty/count. It is instantiated with width ID_W+WIDTH.
- The round-robin arbiter and tag pipeline are inline. The datapath is external and not instantiated here.

## Test plan
- Single op: NREQ=4, LATENCY=5. req_valid[2]=1 with data 0x3C, datapath = identity delay.
  - Expect req_ready[2] that cycle.
  - Expect rsp_valid 7 cycles later with rsp_id=2, rsp_data=0x3C.
- Fairness: all four requesters valid continuously, rsp_ready=1.
  - Expect grants 0,1,2,3,0,…, one per cycle.
  - Expect responses with ids in the same order and no bubbles after the initial 7-cycle fill.
- Backpressure: DEPTH=8, rsp_ready=0, requester 1 always valid.
  - Expect exactly 8 handshakes, then req_ready=0.
  - Raise rsp_ready for one cycle: one pop, then exactly one new grant the next cycle.
- Full FIFO simultaneous push/pop: hold the FIFO full with rsp_ready=1 and stream issues.
  - Expect no loss, order preserved, cnt never exceeding 8.
- Reset mid-flight: issue 3 ops, assert reset_n=0 asynchronously between edges.
  - Expect all outputs 0 immediately.
  - After release, expect no rsp_valid from the stale datapath outputs, and ptr restarting at requester 0.
- Idle gaps: sparse random req_valid with ~50% rsp_ready, 10k cycles.
  - Scoreboard per-requester data/ID ordering.
  - Assert one-hot-or-zero req_ready and no FIFO overflow.

Source files
------------

// File: rtl/pipe_sched_pkg.sv
// Shared definitions for the pipelined round-robin scheduler.
package pipe_sched_pkg;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sched_fifo.sv
// First-word-fall-through response FIFO. Accepts push and pop in the same
// cycle even when full. The head reads as zero while the FIFO is empty.
module sched_fifo
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
)(
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = o_empty ? '0 : r_mem[r_rd];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage holds data only, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointers and occupancy; pointers wrap explicitly for non-power-of-two depths.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule

// File: rtl/pipe_share_sched.sv
// Round-robin scheduler sharing one fixed-latency, non-stallable datapath
// among NREQ requesters. Credits cover the issue register, the tag pipe and
// the response FIFO, so results always have a FIFO slot when they emerge.
module pipe_share_sched
    import pipe_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int LATENCY = 5,
    parameter int DEPTH   = 8
)(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      pipe_in_valid,
    output logic [WIDTH-1:0]          pipe_in_data,
    input  logic [WIDTH-1:0]          pipe_out_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [id_width(NREQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]          rsp_data
);
    localparam int ID_W = id_width(NREQ);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CREDITS = CW'(DEPTH);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [CW-1:0]        r_cnt;
    logic [ID_W-1:0]      r_ptr;
    logic                 r_iss_vld;
    logic [ID_W-1:0]      r_iss_id;
    logic [WIDTH-1:0]     r_iss_data;
    tag_t                 r_tag [LATENCY];

    logic                 w_permit;
    logic                 w_grant_any;
    logic [ID_W-1:0]      w_grant_idx;
    logic [ID_W-1:0]      w_idx;
    logic [NREQ-1:0]      w_grant_vec;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [ID_W+WIDTH-1:0] w_fifo_wdata;
    logic [ID_W+WIDTH-1:0] w_fifo_rdata;
    logic [CW-1:0]        w_fifo_count;
    logic                 w_unused_fifo;

    // Registered credit count gates issue, so a freed credit is usable next cycle.
    assign w_permit = reset_n && (r_cnt < CREDITS);

    // Round-robin search starting at r_ptr; first valid requester wins.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_idx       = '0;
        w_grant_vec = '0;
        if (w_permit) begin
            for (int k = 0; k < NREQ; k++) begin
                w_idx = ID_W'((int'(r_ptr) + k) % NREQ);
                if (!w_grant_any && req_valid[w_idx]) begin
                    w_grant_any = 1'b1;
                    w_grant_idx = w_idx;
                end
            end
            if (w_grant_any) begin
                w_grant_vec[w_grant_idx] = 1'b1;
            end
        end
    end

    assign req_ready = w_grant_vec;

    // Issue register captures the granted operand and advances the pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_iss_vld  <= 1'b0;
            r_iss_id   <= '0;
            r_iss_data <= '0;
            r_ptr      <= '0;
        end else begin
            r_iss_vld <= w_grant_any;
            if (w_grant_any) begin
                r_iss_id   <= w_grant_idx;
                r_iss_data <= req_data[int'(w_grant_idx)*WIDTH +: WIDTH];
                r_ptr      <= (int'(w_grant_idx) == NREQ - 1) ? '0 : w_grant_idx + 1'b1;
            end
        end
    end

    assign pipe_in_valid = r_iss_vld;
    assign pipe_in_data  = r_iss_data;

    // Tag pipe mirrors the external datapath; clearing it drops stale results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < LATENCY; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0] <= tag_t'{valid: r_iss_vld, id: r_iss_id};
            for (int s = 1; s < LATENCY; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    assign w_push       = r_tag[LATENCY-1].valid;
    assign w_fifo_wdata = {r_tag[LATENCY-1].id, pipe_out_data};
    assign w_pop        = rsp_valid & rsp_ready;

    // Outstanding work: +1 per issue, -1 per response handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(w_grant_any) - CW'(w_pop);
        end
    end

    sched_fifo #(
        .WIDTH (ID_W + WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_push  (w_push),
        .i_data  (w_fifo_wdata),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Credits already bound occupancy; full/count are kept for observation only.
    assign w_unused_fifo = ^{w_fifo_full, w_fifo_count};

    assign rsp_valid          = ~w_fifo_empty;
    assign {rsp_id, rsp_data} = w_fifo_rdata;

endmodule

// File: tb/tb_pipe_share_sched.sv
// Bench for pipe_share_sched: directed scenarios plus a long random run,
// all checked every cycle against a queue-based reference model.
module tb_pipe_share_sched;
    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int LATENCY = 5;
    localparam int DEPTH   = 8;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  pipe_in_valid;
    logic [WIDTH-1:0]      pipe_in_data;
    logic [WIDTH-1:0]      pipe_out_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [WIDTH-1:0]      rsp_data;

    always #5 clk = ~clk;

    pipe_share_sched #(
        .NREQ(NREQ), .WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .pipe_in_valid (pipe_in_valid),
        .pipe_in_data  (pipe_in_data),
        .pipe_out_data (pipe_out_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data)
    );

    // External datapath: identity delay of LATENCY flops, never reset.
    logic [WIDTH-1:0] dp [LATENCY];
    always @(posedge clk) begin
        dp[0] <= pipe_in_data;
        for (int s = 1; s < LATENCY; s++) dp[s] <= dp[s-1];
    end
    assign pipe_out_data = dp[LATENCY-1];

    // Reference model state
    typedef struct {
        int               id;
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;
    exp_t             q[$];
    int               mptr, mcnt, cyc;
    logic             prev_acc;
    logic [WIDTH-1:0] prev_data;
    logic [NREQ-1:0]  hs_vec;

    // Last sampled DUT outputs, for directed literal checks
    logic [NREQ-1:0]  s_ready;
    logic             s_rv;
    logic [ID_W-1:0]  s_id;
    logic [WIDTH-1:0] s_data;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare DUT outputs with the model, then advance the model by one cycle.
    task automatic model_step();
        logic [NREQ-1:0] exp_rdy;
        logic            exp_rv;
        int              gidx;
        int              idx;
        s_ready = req_ready;
        s_rv    = rsp_valid;
        s_id    = rsp_id;
        s_data  = rsp_data;
        cyc++;
        hs_vec  = '0;
        if (!reset_n) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_pipe_in_valid", 32'(pipe_in_valid), 0);
            chk("rst_pipe_in_data", 32'(pipe_in_data), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_id", 32'(rsp_id), 0);
            chk("rst_rsp_data", 32'(rsp_data), 0);
            q.delete();
            mptr = 0;
            mcnt = 0;
            prev_acc = 1'b0;
            return;
        end
        chk("one_hot_ready", 32'($countones(req_ready) <= 1), 1);
        chk("no_fifo_overflow", 32'(dut.w_push & dut.w_fifo_full & ~dut.w_pop), 0);
        chk("pipe_in_valid", 32'(pipe_in_valid), 32'(prev_acc));
        if (prev_acc) chk("pipe_in_data", 32'(pipe_in_data), 32'(prev_data));
        gidx = -1;
        if (mcnt < DEPTH) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (mptr + k) % NREQ;
                if (gidx < 0 && req_valid[idx]) gidx = idx;
            end
        end
        exp_rdy = '0;
        if (gidx >= 0) exp_rdy[gidx] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        exp_rv = (q.size() > 0) && (q[0].due <= cyc);
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        if (exp_rv && rsp_valid) begin
            chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
            chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
        end
        hs_vec = req_valid & req_ready;
        if (exp_rv && rsp_ready) begin
            void'(q.pop_front());
            mcnt--;
        end
        prev_acc = (gidx >= 0);
        if (gidx >= 0) begin
            prev_data = req_data[gidx*WIDTH +: WIDTH];
            q.push_back(exp_t'{gidx, prev_data, cyc + LATENCY + 2});
            mcnt++;
            mptr = (gidx + 1) % NREQ;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int nh;
        reset_n   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        cyc = 0; mptr = 0; mcnt = 0; prev_acc = 1'b0; prev_data = '0; hs_vec = '0;
        repeat (3) cycle();
        chk("reset_ready", 32'(s_ready), 0);
        chk("reset_rsp_valid", 32'(s_rv), 0);
        reset_n = 1'b1;

        // Single operation from requester 2
        req_valid = 4'b0100;
        req_data[2*WIDTH +: WIDTH] = 8'h3C;
        rsp_ready = 1'b1;
        cycle();
        chk("single_grant", 32'(s_ready), 32'h4);
        req_valid = '0;
        repeat (6) cycle();
        chk("single_not_early", 32'(s_rv), 0);
        cycle();
        chk("single_rsp_valid", 32'(s_rv), 1);
        chk("single_rsp_id", 32'(s_id), 2);
        chk("single_rsp_data", 32'(s_data), 32'h3C);
        repeat (3) cycle();

        // Fairness with everyone valid and no backpressure
        do_reset();
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            req_data = 32'($urandom);
            cycle();
            chk("fair_grant", 32'(s_ready), 32'(1 << (k % 4)));
            if (k >= 7) begin
                chk("fair_rsp_valid", 32'(s_rv), 1);
                chk("fair_rsp_id", 32'(s_id), 32'((k - 7) % 4));
            end
        end

        // Backpressure: credits run out after DEPTH handshakes
        do_reset();
        req_valid = 4'b0010;
        nh = 0;
        for (int k = 0; k < 20; k++) begin
            req_data[1*WIDTH +: WIDTH] = 8'(k + 8'h40);
            cycle();
            if (s_ready[1]) nh++;
        end
        chk("bp_handshakes", 32'(nh), 8);
        chk("bp_stalled", 32'(s_ready), 0);
        rsp_ready = 1'b1;
        cycle();
        chk("bp_pop_no_grant", 32'(s_ready), 0);
        chk("bp_pop_head", 32'(s_rv), 1);
        rsp_ready = 1'b0;
        cycle();
        chk("bp_regrant", 32'(s_ready), 32'h2);
        cycle();
        chk("bp_stalled_again", 32'(s_ready), 0);

        // Stream issues while the FIFO starts full
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 40; k++) begin
            req_data = 32'($urandom);
            cycle();
        end

        // Asynchronous reset with operations in flight
        do_reset();
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        repeat (3) cycle();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_req_ready", 32'(req_ready), 0);
        chk("async_pipe_in_valid", 32'(pipe_in_valid), 0);
        chk("async_pipe_in_data", 32'(pipe_in_data), 0);
        chk("async_rsp_valid", 32'(rsp_valid), 0);
        chk("async_rsp_id", 32'(rsp_id), 0);
        chk("async_rsp_data", 32'(rsp_data), 0);
        repeat (2) cycle();
        reset_n   = 1'b1;
        req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("stale_rsp_valid", 32'(s_rv), 0);
        end
        req_valid = 4'b1111;
        cycle();
        chk("ptr_restart", 32'(s_ready), 32'h1);

        // Sparse random traffic, requesters hold until accepted
        for (int k = 0; k < 10000; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || hs_vec[i]) begin
                    req_valid[i] = ($urandom_range(3) == 0);
                    req_data[i*WIDTH +: WIDTH] = 8'($urandom);
                end
            end
            rsp_ready = 1'($urandom_range(1));
            cycle();
        end

        // Drain
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (20) cycle();
        chk("drain_rsp_valid", 32'(s_rv), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
